// File: rtl/mul_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : mul_step_sequencer
// Brief    : 32x32->64 signed/unsigned multiply sequenced over the shared ALU.
// Revision : 1.0 - initial release
// ============================================================================
module mul_step_sequencer (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Start,
    input  logic        Signed,
    input  logic [31:0] Multiplicand,
    input  logic [31:0] Multiplier,
    input  logic [31:0] AluOut,
    input  logic        AluC,
    output logic [5:0]  AluOp,
    output logic [31:0] AluA,
    output logic [31:0] AluB,
    output logic        AluCin,
    output logic        Busy,
    output logic        Done,
    output logic [31:0] ProductHi,
    output logic [31:0] ProductLo
);

    localparam logic [2:0] c_st_idle  = 3'd0;
    localparam logic [2:0] c_st_nega  = 3'd1;
    localparam logic [2:0] c_st_negb  = 3'd2;
    localparam logic [2:0] c_st_mul   = 3'd3;
    localparam logic [2:0] c_st_fixlo = 3'd4;
    localparam logic [2:0] c_st_fixhi = 3'd5;
    localparam logic [2:0] c_st_done  = 3'd6;

    localparam logic [5:0] c_op_add   = 6'b000000;
    localparam logic [5:0] c_op_sub   = 6'b000100;
    localparam logic [5:0] c_op_addcc = 6'b010000;
    localparam logic [5:0] c_op_subcc = 6'b010100;
    localparam logic [5:0] c_op_subx  = 6'b001100;

    logic [2:0]  r_state;
    logic [31:0] r_m;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic [4:0]  r_cnt;
    logic        r_neg;
    logic        r_b;
    logic [31:0] r_prod_hi;
    logic [31:0] r_prod_lo;

    // One shift-and-add step: carry and sum enter at the top, P shifts right.
    logic [31:0] w_step_hi;
    logic [31:0] w_step_lo;

    assign w_step_hi = {AluC, AluOut[31:1]};
    assign w_step_lo = {AluOut[0], r_lo[31:1]};

    assign Busy      = (r_state != c_st_idle) && (r_state != c_st_done);
    assign Done      = (r_state == c_st_done);
    assign ProductHi = r_prod_hi;
    assign ProductLo = r_prod_lo;

    always_comb begin
        AluOp  = c_op_add;
        AluA   = 32'd0;
        AluB   = 32'd0;
        AluCin = 1'b0;
        case (r_state)
            c_st_nega: begin
                AluOp = c_op_sub;
                AluB  = r_m;
            end
            c_st_negb: begin
                AluOp = c_op_sub;
                AluB  = r_lo;
            end
            c_st_mul: begin
                AluOp = c_op_addcc;
                AluA  = r_hi;
                AluB  = r_lo[0] ? r_m : 32'd0;
            end
            c_st_fixlo: begin
                AluOp = c_op_subcc;
                AluB  = r_lo;
            end
            c_st_fixhi: begin
                AluOp  = c_op_subx;
                AluB   = r_hi;
                AluCin = r_b;
            end
            default: begin
                AluOp  = c_op_add;
                AluA   = 32'd0;
                AluB   = 32'd0;
                AluCin = 1'b0;
            end
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            r_state   <= c_st_idle;
            r_m       <= 32'd0;
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_cnt     <= 5'd0;
            r_neg     <= 1'b0;
            r_b       <= 1'b0;
            r_prod_hi <= 32'd0;
            r_prod_lo <= 32'd0;
        end else begin
            case (r_state)
                c_st_idle: begin
                    if (Start) begin
                        r_m     <= Multiplicand;
                        r_lo    <= Multiplier;
                        r_hi    <= 32'd0;
                        r_cnt   <= 5'd0;
                        r_b     <= 1'b0;
                        r_neg   <= Signed & (Multiplicand[31] ^ Multiplier[31]);
                        r_state <= Signed ? c_st_nega : c_st_mul;
                    end
                end
                c_st_nega: begin
                    if (r_m[31]) r_m <= AluOut;
                    r_state <= c_st_negb;
                end
                c_st_negb: begin
                    if (r_lo[31]) r_lo <= AluOut;
                    r_state <= c_st_mul;
                end
                c_st_mul: begin
                    r_hi  <= w_step_hi;
                    r_lo  <= w_step_lo;
                    r_cnt <= r_cnt + 5'd1;
                    if (r_cnt == 5'd31) begin
                        if (r_neg) begin
                            r_state <= c_st_fixlo;
                        end else begin
                            r_state   <= c_st_done;
                            r_prod_hi <= w_step_hi;
                            r_prod_lo <= w_step_lo;
                        end
                    end
                end
                // Borrow out of 0-Lo is set exactly when Lo is non-zero.
                c_st_fixlo: begin
                    r_lo    <= AluOut;
                    r_b     <= AluC;
                    r_state <= c_st_fixhi;
                end
                c_st_fixhi: begin
                    r_hi      <= AluOut;
                    r_prod_hi <= AluOut;
                    r_prod_lo <= r_lo;
                    r_state   <= c_st_done;
                end
                c_st_done: begin
                    r_state <= c_st_idle;
                end
                default: begin
                    r_state <= c_st_idle;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mul_step_sequencer.sv
`default_nettype none
// ============================================================================
// Module   : tb_mul_step_sequencer
// Brief    : Scoreboard bench for mul_step_sequencer with a behavioural ALU.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mul_step_sequencer;

    logic        Clk;
    logic        Reset;
    logic        Start;
    logic        Signed;
    logic [31:0] Multiplicand;
    logic [31:0] Multiplier;
    logic [31:0] AluOut;
    logic        AluC;
    logic [5:0]  AluOp;
    logic [31:0] AluA;
    logic [31:0] AluB;
    logic        AluCin;
    logic        Busy;
    logic        Done;
    logic [31:0] ProductHi;
    logic [31:0] ProductLo;

    mul_step_sequencer dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Start        (Start),
        .Signed       (Signed),
        .Multiplicand (Multiplicand),
        .Multiplier   (Multiplier),
        .AluOut       (AluOut),
        .AluC         (AluC),
        .AluOp        (AluOp),
        .AluA         (AluA),
        .AluB         (AluB),
        .AluCin       (AluCin),
        .Busy         (Busy),
        .Done         (Done),
        .ProductHi    (ProductHi),
        .ProductLo    (ProductLo)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // Behavioural SPARC integer ALU; bit 32 is carry for adds, borrow for subtracts.
    logic [32:0] w_alu;
    always_comb begin
        w_alu = 33'd0;
        case (AluOp)
            6'b000000, 6'b010000: w_alu = {1'b0, AluA} + {1'b0, AluB} + {32'd0, AluCin};
            6'b000100, 6'b010100: w_alu = {1'b0, AluA} - {1'b0, AluB};
            6'b001100:            w_alu = {1'b0, AluA} - {1'b0, AluB} - {32'd0, AluCin};
            default:              w_alu = 33'd0;
        endcase
    end
    assign AluOut = w_alu[31:0];
    assign AluC   = w_alu[32];

    typedef struct {
        logic [63:0] prod;
        int          done_at;
        int          busy;
        string       name;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   errors   = 0;
    int   ncnt     = 0;
    int   busy_cnt = 0;
    logic saw_subcc   = 1'b0;
    logic saw_subx_c1 = 1'b0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: one pass per falling edge, pops the scoreboard on every Done.
    always @(negedge Clk) begin
        exp_t e;
        ncnt = ncnt + 1;
        if (Reset) busy_cnt = 0;
        else if (Busy) busy_cnt = busy_cnt + 1;
        if (AluOp == 6'b010100) saw_subcc = 1'b1;
        if (AluOp == 6'b001100 && AluCin) saw_subx_c1 = 1'b1;
        if (Done) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: Done high at cycle %0d with nothing outstanding", ncnt);
            end else begin
                e = exp_q.pop_front();
                chk({e.name, "_product"}, {ProductHi, ProductLo}, e.prod);
                chk({e.name, "_latency"}, 64'(ncnt), 64'(e.done_at));
                chk({e.name, "_busy_cycles"}, 64'(busy_cnt), 64'(e.busy));
            end
            busy_cnt = 0;
        end
    end

    task automatic issue(input string name, input logic [31:0] m, input logic [31:0] q,
                         input logic s, input logic [63:0] prod, input int lat,
                         output int at);
        exp_t e;
        @(negedge Clk);
        #1;
        Start        = 1'b1;
        Signed       = s;
        Multiplicand = m;
        Multiplier   = q;
        at           = ncnt;
        e.prod    = prod;
        e.done_at = at + lat;
        e.busy    = lat - 1;
        e.name    = name;
        exp_q.push_back(e);
        @(negedge Clk);
        #1;
        Start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            @(negedge Clk);
            n++;
        end
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d results still outstanding after %0d cycles", name, exp_q.size(), n);
            exp_q.delete();
        end
        @(negedge Clk);
        #1;
    endtask

    task automatic wait_until(input int target);
        while (ncnt < target) @(negedge Clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int at;
        Reset        = 1'b1;
        Start        = 1'b0;
        Signed       = 1'b0;
        Multiplicand = 32'd0;
        Multiplier   = 32'd0;
        repeat (2) @(negedge Clk);
        #1;
        chk("reset_busy_done", {62'd0, Busy, Done}, 64'd0);
        chk("reset_product", {ProductHi, ProductLo}, 64'd0);
        chk("reset_alu_drive", {25'd0, AluOp, AluCin, AluA}, 64'd0);
        chk("reset_alu_b", {32'd0, AluB}, 64'd0);
        Reset = 1'b0;

        issue("u_7x6", 32'd7, 32'd6, 1'b0, 64'h00000000_0000002A, 33, at);
        wait_done("u_7x6");
        chk("idle_alu_drive", {25'd0, AluOp, AluCin, AluA}, 64'd0);

        issue("u_max", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0, 64'hFFFFFFFE_00000001, 33, at);
        wait_done("u_max");

        issue("u_bit31", 32'h80000000, 32'd2, 1'b0, 64'h00000001_00000000, 33, at);
        wait_done("u_bit31");

        saw_subcc   = 1'b0;
        saw_subx_c1 = 1'b0;
        issue("s_m3x5", 32'hFFFFFFFD, 32'd5, 1'b1, 64'hFFFFFFFF_FFFFFFF1, 37, at);
        wait_done("s_m3x5");
        chk("s_m3x5_subcc_seen", {63'd0, saw_subcc}, 64'd1);
        chk("s_m3x5_subx_cin1_seen", {63'd0, saw_subx_c1}, 64'd1);

        issue("s_corner", 32'h80000000, 32'h80000000, 1'b1, 64'h40000000_00000000, 35, at);
        wait_done("s_corner");

        issue("s_m7xm6", 32'hFFFFFFF9, 32'hFFFFFFFA, 1'b1, 64'h00000000_0000002A, 35, at);
        wait_done("s_m7xm6");

        issue("s_0xm1", 32'd0, 32'hFFFFFFFF, 1'b1, 64'd0, 37, at);
        wait_done("s_0xm1");

        // A Start pulse mid-multiply must be dropped entirely.
        issue("busy_first", 32'h00010000, 32'h00010000, 1'b0, 64'h00000001_00000000, 33, at);
        wait_until(at + 10);
        Start        = 1'b1;
        Signed       = 1'b1;
        Multiplicand = 32'd5;
        Multiplier   = 32'd5;
        @(negedge Clk);
        #1;
        Start = 1'b0;
        wait_done("busy_first");
        issue("after_busy", 32'h00001234, 32'h00000010, 1'b0, 64'h00000000_00012340, 33, at);
        wait_done("after_busy");

        issue("rst_mid", 32'h0000FFFF, 32'h0000FFFF, 1'b0, 64'h00000000_FFFE0001, 33, at);
        wait_until(at + 16);
        #1;
        Reset = 1'b1;
        #1;
        chk("rst_mid_busy_done", {62'd0, Busy, Done}, 64'd0);
        chk("rst_mid_product", {ProductHi, ProductLo}, 64'd0);
        exp_q.delete();
        @(negedge Clk);
        #1;
        Reset = 1'b0;
        repeat (40) @(negedge Clk);
        #1;
        chk("rst_mid_no_done", {63'd0, Done}, 64'd0);

        issue("u_3x4", 32'd3, 32'd4, 1'b0, 64'd12, 33, at);
        wait_done("u_3x4");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
